// File: rtl/level_sequencer.sv
// level_sequencer: per-level round controller.
// A prelimSig pulse starts a ready countdown, then a timed play window,
// then the round is judged. A pass advances the level and emits a one-cycle
// newLevel pulse. A fail, or a pass on the last level, ends the game.
// Clk1Hz is sampled as data and turned into one-cycle ticks in the Clk100M domain.
module level_sequencer #(
  parameter int COUNTDOWN_SEC = 3,
  parameter int PLAY_SEC      = 10,
  parameter int MAX_LEVEL     = 9,
  parameter int LVL_W         = 4,
  parameter int SEC_W         = 5
) (
  input  logic             Clk100M,
  input  logic             Rst_n,
  input  logic             Clk1Hz,
  input  logic             prelimSig,
  input  logic             roundDone,
  input  logic             roundPass,
  output logic             newLevel,
  output logic [LVL_W-1:0] level,
  output logic [SEC_W-1:0] secLeft,
  output logic             countingDn,
  output logic             playEnable,
  output logic             gameOver,
  output logic             won
);

  localparam logic [SEC_W-1:0] C_CD_SEC   = SEC_W'(COUNTDOWN_SEC);
  localparam logic [SEC_W-1:0] C_PLAY_SEC = SEC_W'(PLAY_SEC);
  localparam logic [SEC_W-1:0] C_SEC_ONE  = SEC_W'(1);
  localparam logic [SEC_W-1:0] C_SEC_ZERO = '0;
  localparam logic [LVL_W-1:0] C_LVL_MAX  = LVL_W'(MAX_LEVEL);
  localparam logic [LVL_W-1:0] C_LVL_ONE  = LVL_W'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_JUDGE     = 3'd3,
    S_ADVANCE   = 3'd4,
    S_OVER      = 3'd5
  } state_t;

  // Tick pipeline: two synchronizer stages then a delay stage for edge detect.
  logic r_sync1;
  logic r_sync2;
  logic r_dly;
  logic w_tick;

  state_t           r_state;
  logic             r_pass;
  logic [LVL_W-1:0] r_level;
  logic [SEC_W-1:0] r_sec;
  logic             r_cd;
  logic             r_pe;
  logic             r_go;
  logic             r_won;
  logic             r_new;

  state_t           w_state_next;
  logic             w_pass_next;
  logic [LVL_W-1:0] w_level_next;
  logic [SEC_W-1:0] w_sec_next;
  logic             w_cd_next;
  logic             w_pe_next;
  logic             w_go_next;
  logic             w_won_next;
  logic             w_new_next;

  // Synchronize Clk1Hz and keep one extra stage to find its rising edge.
  always_ff @(posedge Clk100M) begin
    if (!Rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_dly   <= 1'b0;
    end else begin
      r_sync1 <= Clk1Hz;
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
    end
  end

  // High for the single cycle after the synchronized level first reads 1;
  // it takes effect on the third edge counting the one that sampled Clk1Hz high.
  assign w_tick = r_sync2 & ~r_dly;

  // State and registered outputs.
  always_ff @(posedge Clk100M) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
      r_pass  <= 1'b0;
      r_level <= C_LVL_ONE;
      r_sec   <= C_SEC_ZERO;
      r_cd    <= 1'b0;
      r_pe    <= 1'b0;
      r_go    <= 1'b0;
      r_won   <= 1'b0;
      r_new   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pass  <= w_pass_next;
      r_level <= w_level_next;
      r_sec   <= w_sec_next;
      r_cd    <= w_cd_next;
      r_pe    <= w_pe_next;
      r_go    <= w_go_next;
      r_won   <= w_won_next;
      r_new   <= w_new_next;
    end
  end

  // Next-state and next-output decisions; everything holds unless changed.
  always_comb begin
    w_state_next = r_state;
    w_pass_next  = r_pass;
    w_level_next = r_level;
    w_sec_next   = r_sec;
    w_cd_next    = r_cd;
    w_pe_next    = r_pe;
    w_go_next    = r_go;
    w_won_next   = r_won;
    w_new_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (prelimSig) begin
          w_state_next = S_COUNTDOWN;
          w_sec_next   = C_CD_SEC;
          w_cd_next    = 1'b1;
        end
      end
      S_COUNTDOWN: begin
        if (w_tick) begin
          if (r_sec > C_SEC_ONE) begin
            w_sec_next = r_sec - C_SEC_ONE;
          end else begin
            w_state_next = S_PLAY;
            w_sec_next   = C_PLAY_SEC;
            w_cd_next    = 1'b0;
            w_pe_next    = 1'b1;
          end
        end
      end
      S_PLAY: begin
        // A submitted answer takes priority over a coincident timeout tick.
        if (roundDone) begin
          w_state_next = S_JUDGE;
          w_pass_next  = roundPass;
          w_pe_next    = 1'b0;
          w_sec_next   = C_SEC_ZERO;
        end else if (w_tick) begin
          if (r_sec > C_SEC_ONE) begin
            w_sec_next = r_sec - C_SEC_ONE;
          end else begin
            w_state_next = S_JUDGE;
            w_pass_next  = 1'b0;
            w_pe_next    = 1'b0;
            w_sec_next   = C_SEC_ZERO;
          end
        end
      end
      S_JUDGE: begin
        if (r_pass && (r_level < C_LVL_MAX)) begin
          w_state_next = S_ADVANCE;
        end else begin
          w_state_next = S_OVER;
          w_go_next    = 1'b1;
          w_won_next   = r_pass;
        end
      end
      S_ADVANCE: begin
        if (r_level < C_LVL_MAX) begin
          w_level_next = r_level + C_LVL_ONE;
        end
        w_new_next   = 1'b1;
        w_state_next = S_IDLE;
      end
      S_OVER: begin
        // Terminal until reset.
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign newLevel   = r_new;
  assign level      = r_level;
  assign secLeft    = r_sec;
  assign countingDn = r_cd;
  assign playEnable = r_pe;
  assign gameOver   = r_go;
  assign won        = r_won;

endmodule

// File: tb/tb_level_sequencer.sv
// Testbench for level_sequencer with short countdown/play windows and two levels.
module tb_level_sequencer;

  localparam int CD_SEC  = 2;
  localparam int PL_SEC  = 3;
  localparam int MAX_LVL = 2;

  localparam int OP_RST  = 0;
  localparam int OP_PRE  = 1;
  localparam int OP_TICK = 2;
  localparam int OP_DONE = 3;
  localparam int OP_WAIT = 4;

  localparam int M_IDLE = 0;
  localparam int M_CD   = 1;
  localparam int M_PLAY = 2;
  localparam int M_OVER = 3;

  logic       clk;
  logic       rst_n;
  logic       clk1hz;
  logic       prelim_drv;
  logic       fb_en;
  logic       round_done;
  logic       round_pass;
  logic       w_prelim;
  logic       new_level;
  logic [3:0] level;
  logic [4:0] sec_left;
  logic       counting_dn;
  logic       play_enable;
  logic       game_over;
  logic       won;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_phase;
  int m_level;
  int m_sec;
  int m_won;

  typedef struct {
    int op;
    int arg;
    int lvl;
    int sec;
    int cd;
    int pe;
    int go;
    int wn;
  } vec_t;

  vec_t tbl[$];

  assign w_prelim = prelim_drv | (fb_en & new_level);

  level_sequencer #(
    .COUNTDOWN_SEC(CD_SEC),
    .PLAY_SEC     (PL_SEC),
    .MAX_LEVEL    (MAX_LVL),
    .LVL_W        (4),
    .SEC_W        (5)
  ) dut (
    .Clk100M   (clk),
    .Rst_n     (rst_n),
    .Clk1Hz    (clk1hz),
    .prelimSig (w_prelim),
    .roundDone (round_done),
    .roundPass (round_pass),
    .newLevel  (new_level),
    .level     (level),
    .secLeft   (sec_left),
    .countingDn(counting_dn),
    .playEnable(play_enable),
    .gameOver  (game_over),
    .won       (won)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_outs(input string name, input int lvl, input int sec, input int cd,
                            input int pe, input int go, input int wn, input int nl);
    logic [12:0] got_v;
    logic [12:0] exp_v;
    got_v = {level, sec_left, counting_dn, play_enable, game_over, won};
    exp_v = {lvl[3:0], sec[4:0], cd[0], pe[0], go[0], wn[0]};
    checks++;
    if (got_v !== exp_v || new_level !== nl[0]) begin
      errors++;
      $display("FAIL %s got lvl=%0d sec=%0d cd=%b pe=%b go=%b won=%b nl=%b exp lvl=%0d sec=%0d cd=%0d pe=%0d go=%0d won=%0d nl=%0d",
               name, level, sec_left, counting_dn, play_enable, game_over, won, new_level,
               lvl, sec, cd, pe, go, wn, nl);
    end else begin
      $display("ok   %s lvl=%0d sec=%0d cd=%b pe=%b go=%b won=%b nl=%b",
               name, level, sec_left, counting_dn, play_enable, game_over, won, new_level);
    end
  endtask

  task automatic apply_op(input int op, input int arg);
    case (op)
      OP_RST: begin
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
      end
      OP_PRE: begin
        @(negedge clk) prelim_drv = 1'b1;
        @(negedge clk) prelim_drv = 1'b0;
        repeat (2) @(negedge clk);
      end
      OP_TICK: begin
        @(negedge clk) clk1hz = 1'b1;
        repeat (6) @(negedge clk);
        clk1hz = 1'b0;
        repeat (6) @(negedge clk);
      end
      OP_DONE: begin
        @(negedge clk);
        round_done = 1'b1;
        round_pass = arg[0];
        @(negedge clk);
        round_done = 1'b0;
        round_pass = 1'b0;
        repeat (4) @(negedge clk);
      end
      default: begin
        round_pass = 1'($urandom_range(0, 1));
        repeat (arg) @(negedge clk);
        round_pass = 1'b0;
      end
    endcase
  endtask

  // Game rules applied at whole-transaction granularity.
  task automatic model_op(input int op, input int arg);
    case (op)
      OP_RST: begin
        m_phase = M_IDLE; m_level = 1; m_sec = 0; m_won = 0;
      end
      OP_PRE: begin
        if (m_phase == M_IDLE) begin
          m_phase = M_CD; m_sec = CD_SEC;
        end
      end
      OP_TICK: begin
        if (m_phase == M_CD) begin
          if (m_sec > 1) m_sec = m_sec - 1;
          else begin m_phase = M_PLAY; m_sec = PL_SEC; end
        end else if (m_phase == M_PLAY) begin
          if (m_sec > 1) m_sec = m_sec - 1;
          else begin m_phase = M_OVER; m_sec = 0; m_won = 0; end
        end
      end
      OP_DONE: begin
        if (m_phase == M_PLAY) begin
          m_sec = 0;
          if (arg != 0 && m_level < MAX_LVL) begin
            m_level = m_level + 1; m_phase = M_IDLE;
          end else begin
            m_phase = M_OVER; m_won = (arg != 0) ? 1 : 0;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic add(input int op, input int arg, input int lvl, input int sec,
                     input int cd, input int pe, input int go, input int wn);
    vec_t v;
    v.op = op; v.arg = arg; v.lvl = lvl; v.sec = sec;
    v.cd = cd; v.pe = pe; v.go = go; v.wn = wn;
    tbl.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0; clk1hz = 1'b0; prelim_drv = 1'b0; fb_en = 1'b0;
    round_done = 1'b0; round_pass = 1'b0;
    repeat (3) @(negedge clk);

    // op, arg, level, secLeft, countingDn, playEnable, gameOver, won
    add(OP_RST,  0, 1, 0, 0, 0, 0, 0);
    add(OP_TICK, 0, 1, 0, 0, 0, 0, 0);
    add(OP_WAIT, 5, 1, 0, 0, 0, 0, 0);
    add(OP_PRE,  0, 1, 2, 1, 0, 0, 0);
    add(OP_TICK, 0, 1, 1, 1, 0, 0, 0);
    add(OP_TICK, 0, 1, 3, 0, 1, 0, 0);
    add(OP_TICK, 0, 1, 2, 0, 1, 0, 0);
    add(OP_PRE,  0, 1, 2, 0, 1, 0, 0);
    add(OP_DONE, 1, 2, 0, 0, 0, 0, 0);
    add(OP_PRE,  0, 2, 2, 1, 0, 0, 0);
    add(OP_DONE, 1, 2, 2, 1, 0, 0, 0);
    add(OP_TICK, 0, 2, 1, 1, 0, 0, 0);
    add(OP_TICK, 0, 2, 3, 0, 1, 0, 0);
    add(OP_DONE, 1, 2, 0, 0, 0, 1, 1);
    add(OP_PRE,  0, 2, 0, 0, 0, 1, 1);
    add(OP_TICK, 0, 2, 0, 0, 0, 1, 1);
    add(OP_DONE, 1, 2, 0, 0, 0, 1, 1);
    add(OP_RST,  0, 1, 0, 0, 0, 0, 0);
    add(OP_PRE,  0, 1, 2, 1, 0, 0, 0);
    add(OP_TICK, 0, 1, 1, 1, 0, 0, 0);
    add(OP_TICK, 0, 1, 3, 0, 1, 0, 0);
    add(OP_TICK, 0, 1, 2, 0, 1, 0, 0);
    add(OP_TICK, 0, 1, 1, 0, 1, 0, 0);
    add(OP_TICK, 0, 1, 0, 0, 0, 1, 0);
    add(OP_RST,  0, 1, 0, 0, 0, 0, 0);
    add(OP_DONE, 1, 1, 0, 0, 0, 0, 0);
    add(OP_PRE,  0, 1, 2, 1, 0, 0, 0);
    add(OP_TICK, 0, 1, 1, 1, 0, 0, 0);
    add(OP_TICK, 0, 1, 3, 0, 1, 0, 0);
    add(OP_DONE, 0, 1, 0, 0, 0, 1, 0);

    foreach (tbl[i]) begin
      apply_op(tbl[i].op, tbl[i].arg);
      check_outs($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].sec, tbl[i].cd,
                 tbl[i].pe, tbl[i].go, tbl[i].wn, 0);
    end

    // newLevel latency and feedback into prelimSig
    apply_op(OP_RST, 0); apply_op(OP_PRE, 0); apply_op(OP_TICK, 0); apply_op(OP_TICK, 0);
    fb_en = 1'b1;
    @(negedge clk); round_done = 1'b1; round_pass = 1'b1;
    @(negedge clk); round_done = 1'b0; round_pass = 1'b0;
    check_outs("lat_n0", 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_outs("lat_n1", 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_outs("lat_n2", 2, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check_outs("lat_fb", 2, 2, 1, 0, 0, 0, 0);
    fb_en = 1'b0;

    // roundDone on the same edge as the final play tick wins
    apply_op(OP_RST, 0); apply_op(OP_PRE, 0);
    repeat (4) apply_op(OP_TICK, 0);
    check_outs("coin_pre", 1, 1, 0, 1, 0, 0, 0);
    @(negedge clk) clk1hz = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk); round_done = 1'b1; round_pass = 1'b1;
    @(negedge clk); round_done = 1'b0; round_pass = 1'b0;
    repeat (4) @(negedge clk);
    check_outs("coin_pass", 2, 0, 0, 0, 0, 0, 0);
    clk1hz = 1'b0; repeat (4) @(negedge clk);

    // one cycle after the final tick the answer is too late
    apply_op(OP_RST, 0); apply_op(OP_PRE, 0);
    repeat (4) apply_op(OP_TICK, 0);
    @(negedge clk) clk1hz = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk);
    @(negedge clk); round_done = 1'b1; round_pass = 1'b1;
    @(negedge clk); round_done = 1'b0; round_pass = 1'b0;
    repeat (4) @(negedge clk);
    check_outs("late_done", 1, 0, 0, 0, 1, 0, 0);
    clk1hz = 1'b0; repeat (4) @(negedge clk);

    // reset mid-play with a tick in flight
    apply_op(OP_RST, 0); apply_op(OP_PRE, 0);
    repeat (3) apply_op(OP_TICK, 0);
    check_outs("rst_pre", 1, 2, 0, 1, 0, 0, 0);
    @(negedge clk) clk1hz = 1'b1;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    check_outs("rst_mid", 1, 0, 0, 0, 0, 0, 0);
    repeat (6) @(negedge clk);
    check_outs("rst_hold", 1, 0, 0, 0, 0, 0, 0);
    apply_op(OP_PRE, 0);
    repeat (6) @(negedge clk);
    check_outs("rst_nopend", 1, 2, 1, 0, 0, 0, 0);
    clk1hz = 1'b0; repeat (4) @(negedge clk);

    // randomized play against the reference model
    apply_op(OP_RST, 0);
    model_op(OP_RST, 0);
    for (int n = 0; n < 300; n++) begin
      int r;
      int op;
      int arg;
      arg = 0;
      r = int'($urandom_range(0, 19));
      if (m_phase == M_OVER && r < 6) op = OP_RST;
      else if (r == 0)  op = OP_RST;
      else if (r <= 4)  op = OP_PRE;
      else if (r <= 11) op = OP_TICK;
      else if (r <= 16) begin op = OP_DONE; arg = int'($urandom_range(0, 1)); end
      else begin op = OP_WAIT; arg = int'($urandom_range(1, 5)); end
      apply_op(op, arg);
      model_op(op, arg);
      check_outs($sformatf("rand%0d op%0d arg%0d", n, op, arg), m_level, m_sec,
                 (m_phase == M_CD) ? 1 : 0, (m_phase == M_PLAY) ? 1 : 0,
                 (m_phase == M_OVER) ? 1 : 0, m_won, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
